// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath: weight word format and the
// weight feeder state encoding.
package tpu_pkg;

  // Weights are Q8.8 fixed point: 8 integer bits, 8 fractional bits.
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    WF_IDLE   = 2'd0,
    WF_LOAD   = 2'd1,
    WF_PRIMED = 2'd2,
    WF_SWITCH = 2'd3
  } wf_state_e;

endpackage : tpu_pkg

// File: rtl/weight_feeder.sv
// Streams one weight tile (last row first) into a PE column through a
// registered shift port, then issues a single-cycle switch to activate it.
module weight_feeder #(
  parameter int ROWS   = 2,
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wf_start_in,
  input  logic              wf_weight_valid_in,
  input  logic [DATA_W-1:0] wf_weight_in,
  output logic              wf_weight_ready_out,
  input  logic              wf_switch_req_in,
  output logic [DATA_W-1:0] wf_weight_out,
  output logic              wf_accept_w_out,
  output logic              wf_switch_out,
  output logic              wf_busy_out,
  output logic              wf_done_out
);
  import tpu_pkg::*;

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  wf_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic              accept_q, accept_d;
  logic              xfer;

  // Ready is a pure function of state, so a transfer is just valid while loading.
  assign xfer = (state_q == WF_LOAD) && wf_weight_valid_in;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    accept_d = 1'b0;

    unique case (state_q)
      WF_IDLE: begin
        if (wf_start_in) begin
          state_d = WF_LOAD;
          cnt_d   = '0;
        end
      end
      WF_LOAD: begin
        if (xfer) begin
          weight_d = wf_weight_in;
          accept_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ROW) state_d = WF_PRIMED;
        end
      end
      WF_PRIMED: begin
        if (wf_switch_req_in) state_d = WF_SWITCH;
      end
      WF_SWITCH: begin
        state_d = WF_IDLE;
      end
      default: begin
        state_d = WF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= WF_IDLE;
      cnt_q    <= '0;
      weight_q <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      accept_q <= accept_d;
    end
  end

  // The last transfer lands in PRIMED, so accept and switch can never overlap.
  assign wf_weight_ready_out = (state_q == WF_LOAD);
  assign wf_weight_out       = weight_q;
  assign wf_accept_w_out     = accept_q;
  assign wf_switch_out       = (state_q == WF_SWITCH);
  assign wf_done_out         = (state_q == WF_SWITCH);
  assign wf_busy_out         = (state_q != WF_IDLE);

endmodule : weight_feeder

// File: tb/tb_weight_feeder.sv
// Directed bench for weight_feeder (ROWS=2): back-to-back and stalled loads,
// delayed and early switch requests, reset mid-tile, and extra words in PRIMED.
module tb_weight_feeder;

  localparam int ROWS   = 2;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              valid;
  logic [DATA_W-1:0] word;
  logic              ready;
  logic              switch_req;
  logic [DATA_W-1:0] weight_out;
  logic              accept_w;
  logic              switch_o;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;

  weight_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wf_start_in         (start),
    .wf_weight_valid_in  (valid),
    .wf_weight_in        (word),
    .wf_weight_ready_out (ready),
    .wf_switch_req_in    (switch_req),
    .wf_weight_out       (weight_out),
    .wf_accept_w_out     (accept_w),
    .wf_switch_out       (switch_o),
    .wf_busy_out         (busy),
    .wf_done_out         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [DATA_W-1:0] w, input logic acc,
                           input logic rdy, input logic sw, input logic bsy);
    check({tag, ".weight"}, 32'(weight_out), 32'(w));
    check({tag, ".accept"}, 32'(accept_w), 32'(acc));
    check({tag, ".ready"},  32'(ready), 32'(rdy));
    check({tag, ".switch"}, 32'(switch_o), 32'(sw));
    check({tag, ".done"},   32'(done), 32'(sw));
    check({tag, ".busy"},   32'(busy), 32'(bsy));
  endtask

  initial begin
    // Reset dominates simultaneous start/valid/switch_req.
    rst = 1'b1; start = 1'b1; valid = 1'b1; word = 16'h7777; switch_req = 1'b1;
    tick();
    tick();
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0; valid = 1'b0; switch_req = 1'b0;
    tick();
    check_all("idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back load of 69.0 then 10.0; switch_req in LOAD ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("b2b.load", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    valid = 1'b1; word = 16'h4500;
    tick();
    check_all("b2b.w0", 16'h4500, 1'b1, 1'b1, 1'b0, 1'b1);
    word = 16'h0A00;
    tick();
    check_all("b2b.w1", 16'h0A00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Third word offered in PRIMED is not consumed; start also ignored.
    word = 16'h1234; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("primed.extra", 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
    end
    valid = 1'b0;

    // Switch request arrives late: exactly one pulse then idle.
    switch_req = 1'b1;
    tick();
    check_all("late.switch", 16'h0A00, 1'b0, 1'b0, 1'b1, 1'b1);
    switch_req = 1'b0;
    tick();
    check_all("late.after", 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("late.idle", 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Valid gap of three cycles between words: column shift stalls in LOAD.
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; word = 16'h4500;
    tick();
    check_all("gap.w0", 16'h4500, 1'b1, 1'b1, 1'b0, 1'b1);
    valid = 1'b0; word = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("gap.stall", 16'h4500, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    valid = 1'b1; word = 16'h0A00;
    tick();
    check_all("gap.w1", 16'h0A00, 1'b1, 1'b0, 1'b0, 1'b1);
    valid = 1'b0; switch_req = 1'b1;
    tick();
    check_all("gap.switch", 16'h0A00, 1'b0, 1'b0, 1'b1, 1'b1);
    switch_req = 1'b0;
    tick();
    check_all("gap.idle", 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0);

    // switch_req held through the whole load: pulse right after PRIMED.
    switch_req = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("early.load", 16'h0A00, 1'b0, 1'b1, 1'b0, 1'b1);
    valid = 1'b1; word = 16'h0180;
    tick();
    check_all("early.w0", 16'h0180, 1'b1, 1'b1, 1'b0, 1'b1);
    word = 16'hFF00;
    tick();
    check_all("early.w1", 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b1);
    valid = 1'b0;
    tick();
    check_all("early.switch", 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_all("early.idle", 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0);
    switch_req = 1'b0;

    // Reset after one transfer abandons the tile.
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; word = 16'h4500;
    tick();
    check_all("rst.w0", 16'h4500, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; word = 16'h0A00; switch_req = 1'b1;
    tick();
    check_all("rst.mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; valid = 1'b0;
    tick();
    check_all("rst.after", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    switch_req = 1'b0;

    // Fresh tile after reset completes normally.
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; word = 16'h4500;
    tick();
    check_all("fresh.w0", 16'h4500, 1'b1, 1'b1, 1'b0, 1'b1);
    word = 16'h0A00;
    tick();
    check_all("fresh.w1", 16'h0A00, 1'b1, 1'b0, 1'b0, 1'b1);
    valid = 1'b0; switch_req = 1'b1;
    tick();
    check_all("fresh.switch", 16'h0A00, 1'b0, 1'b0, 1'b1, 1'b1);
    switch_req = 1'b0;
    tick();
    check_all("fresh.idle", 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_weight_feeder
